// File: rtl/sim_mem_ctrl.sv
// Memory owner and run sequencer for the 8-bit CPU: loads a program from the host,
// commits core stack writes while running, then streams the memory image back out.
module sim_mem_ctrl #(
  parameter int MEMSIZE = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  input  logic [7:0]                load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  output logic                      core_en,
  input  logic                      write_flag,
  input  logic [MEMSIZE-1:0]        write_addr,
  input  logic [7:0]                write_value,
  input  logic [7:0]                ip,
  input  logic [7:0]                next_ip,
  output logic [MEMSIZE-1:0][7:0]   memory,
  output logic                      dump_valid,
  output logic [7:0]                dump_data,
  output logic                      dump_last,
  input  logic                      dump_ready,
  output logic                      done,
  output logic                      timeout,
  output logic [7:0]                cycles,
  output logic [1:0]                state
);

  localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [AW-1:0]      LAST_ADDR   = AW'(MEMSIZE - 1);
  localparam logic [MEMSIZE-1:0] ADDR_BOUND  = MEMSIZE'(MEMSIZE);
  localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);

  // Handshakes: a byte moves on a rising clock edge when valid and ready are both
  // high; valid never waits for ready, and ready/valid depend only on registered state.

  logic [1:0]    state_next;
  logic [AW-1:0] lptr;
  logic [AW-1:0] dptr;
  logic          load_fire;
  logic          dump_fire;
  logic          core_fire;
  logic          halt;
  logic          last_cycle;

  assign load_ready = (state == ST_LOAD);
  assign core_en    = (state == ST_RUN);
  assign dump_valid = (state == ST_DUMP);
  assign done       = (state == ST_DONE);

  assign load_fire  = load_valid && load_ready;
  assign dump_fire  = dump_valid && dump_ready;
  assign core_fire  = core_en && write_flag && (write_addr < ADDR_BOUND);
  assign halt       = (next_ip == ip);
  assign last_cycle = (cycles == (TIMEOUT_CNT - 8'd1));

  assign dump_data  = dump_valid ? memory[dptr] : 8'h00;
  assign dump_last  = dump_valid && (dptr == LAST_ADDR);

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (load_fire && (load_last || lptr == LAST_ADDR)) state_next = ST_RUN;
      ST_RUN:  if (halt || last_cycle) state_next = ST_DUMP;
      ST_DUMP: if (dump_fire && dptr == LAST_ADDR) state_next = ST_DONE;
      default: state_next = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Writes land on the registered array so the core sees them the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memory <= '0;
    end else if (load_fire) begin
      memory[lptr] <= load_data;
    end else if (core_fire) begin
      memory[write_addr[AW-1:0]] <= write_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lptr <= '0;
    end else if (load_fire && lptr != LAST_ADDR) begin
      lptr <= lptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dptr <= '0;
    end else if (dump_fire && dptr != LAST_ADDR) begin
      dptr <= dptr + 1'b1;
    end
  end

  // Halt has priority over the final allowed cycle, so timeout stays clear then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles  <= 8'd0;
      timeout <= 1'b0;
    end else if (core_en) begin
      cycles <= cycles + 8'd1;
      if (last_cycle && !halt) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sim_mem_ctrl.sv
// Directed bench for sim_mem_ctrl: load, core writes, halt, timeout, dump and reset abort.
module tb_sim_mem_ctrl;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_data = 8'h00;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              core_en;
  logic              write_flag = 1'b0;
  logic [63:0]       write_addr = 64'd0;
  logic [7:0]        write_value = 8'h00;
  logic [7:0]        ip = 8'h00;
  logic [7:0]        next_ip = 8'h01;
  logic [63:0][7:0]  memory;
  logic              dump_valid;
  logic [7:0]        dump_data;
  logic              dump_last;
  logic              dump_ready = 1'b0;
  logic              done;
  logic              timeout;
  logic [7:0]        cycles;
  logic [1:0]        state;

  logic [63:0][7:0]  exp_mem;
  int checks = 0;
  int errors = 0;

  sim_mem_ctrl #(.MEMSIZE(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .core_en(core_en),
    .write_flag(write_flag), .write_addr(write_addr), .write_value(write_value),
    .ip(ip), .next_ip(next_ip), .memory(memory),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready), .done(done), .timeout(timeout), .cycles(cycles),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    checks++;
    assert (memory === exp_mem) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, memory, exp_mem);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    write_flag = 1'b0;
    dump_ready = 1'b0;
    ip = 8'h00;
    next_ip = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_mem = '0;
  endtask

  task automatic send_byte(input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_data = data;
    load_last = last;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    write_flag = 1'b0;
    ip = 8'h00;
    next_ip = 8'h01;
    repeat (n) tick();
  endtask

  initial begin
    int idx;
    int budget;
    logic phase;

    // Reset state
    do_reset();
    check("rst_state", 64'(state), 64'(ST_LOAD));
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_core_en", 64'(core_en), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_dump_last", 64'(dump_last), 64'd0);
    check("rst_dump_data", 64'(dump_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    check_mem("rst_mem");

    // Three-byte load terminated by load_last
    send_byte(8'h44, 1'b0);
    check("load1_core_en", 64'(core_en), 64'd0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hF0, 1'b1);
    exp_mem[0] = 8'h44;
    exp_mem[1] = 8'h05;
    exp_mem[2] = 8'hF0;
    check("load3_core_en", 64'(core_en), 64'd1);
    check("load3_load_ready", 64'(load_ready), 64'd0);
    check("load3_state", 64'(state), 64'(ST_RUN));
    check_mem("load3_mem");

    // RUN cycle 1: in-range write
    write_flag = 1'b1;
    write_addr = 64'd63;
    write_value = 8'hAA;
    tick();
    exp_mem[63] = 8'hAA;
    check_mem("write63_mem");
    check("write63_cycles", 64'(cycles), 64'd1);

    // RUN cycle 2: out-of-range write is dropped
    write_addr = 64'd255;
    write_value = 8'h11;
    tick();
    check_mem("write255_mem");
    check("write255_cycles", 64'(cycles), 64'd2);

    // RUN cycle 3: plain step; cycle 4: halt
    write_flag = 1'b0;
    ip = 8'h01;
    next_ip = 8'h02;
    tick();
    check("run3_core_en", 64'(core_en), 64'd1);
    ip = 8'h05;
    next_ip = 8'h05;
    tick();
    check("halt_cycles", 64'(cycles), 64'd4);
    check("halt_timeout", 64'(timeout), 64'd0);
    check("halt_core_en", 64'(core_en), 64'd0);
    check("halt_dump_valid", 64'(dump_valid), 64'd1);
    check("halt_state", 64'(state), 64'(ST_DUMP));

    // Dump with dump_ready toggling; stalled cycles recheck the same byte
    idx = 0;
    budget = 0;
    phase = 1'b0;
    while (idx < 64 && budget < 400) begin
      dump_ready = phase;
      check("dump_valid", 64'(dump_valid), 64'd1);
      check("dump_data", 64'(dump_data), 64'(exp_mem[idx]));
      check("dump_last", 64'(dump_last), 64'(idx == 63));
      tick();
      if (phase) idx++;
      phase = ~phase;
      budget++;
    end
    dump_ready = 1'b0;
    check("dump_count", 64'(idx), 64'd64);
    check("done_done", 64'(done), 64'd1);
    check("done_dump_valid", 64'(dump_valid), 64'd0);
    check("done_core_en", 64'(core_en), 64'd0);
    check("done_load_ready", 64'(load_ready), 64'd0);
    check("done_state", 64'(state), 64'(ST_DONE));
    tick();
    check("done_sticky", 64'(done), 64'd1);
    check_mem("done_mem");

    // Full 64-byte load without load_last
    do_reset();
    check_mem("reset2_mem");
    for (int i = 0; i < 64; i++) begin
      check("full_load_ready", 64'(load_ready), 64'd1);
      send_byte(8'(i * 7 + 3), 1'b0);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    check("full_state", 64'(state), 64'(ST_RUN));
    check("full_load_ready_low", 64'(load_ready), 64'd0);
    check_mem("full_mem");
    write_flag = 1'b0;
    ip = 8'h00;
    next_ip = 8'h01;
    send_byte(8'hEE, 1'b1);
    check_mem("extra_byte_mem");
    check("extra_byte_state", 64'(state), 64'(ST_RUN));

    // Asynchronous reset mid-RUN
    #2;
    rst_n = 1'b0;
    #1;
    exp_mem = '0;
    check_mem("abort_mem");
    check("abort_state", 64'(state), 64'(ST_LOAD));
    check("abort_core_en", 64'(core_en), 64'd0);
    check("abort_cycles", 64'(cycles), 64'd0);

    // Timeout after 255 RUN cycles with no halt
    do_reset();
    send_byte(8'h77, 1'b1);
    exp_mem[0] = 8'h77;
    run_cycles(254);
    check("to254_core_en", 64'(core_en), 64'd1);
    check("to254_cycles", 64'(cycles), 64'd254);
    run_cycles(1);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_cycles", 64'(cycles), 64'd255);
    check("to_core_en", 64'(core_en), 64'd0);
    check("to_dump_valid", 64'(dump_valid), 64'd1);
    check("to_dump_data", 64'(dump_data), 64'h77);
    run_cycles(3);
    check("to_cycles_hold", 64'(cycles), 64'd255);

    // Halt on the 255th cycle wins over timeout
    do_reset();
    send_byte(8'h77, 1'b1);
    run_cycles(254);
    ip = 8'h09;
    next_ip = 8'h09;
    tick();
    check("halt255_timeout", 64'(timeout), 64'd0);
    check("halt255_cycles", 64'(cycles), 64'd255);
    check("halt255_dump_valid", 64'(dump_valid), 64'd1);
    check("halt255_state", 64'(state), 64'(ST_DUMP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
